// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and state type for the seven-segment display arbiter
//
// Purpose: digit-code constants, digit geometry and the arbiter state enum
//          shared by seg7_lz_blank and seg7_disp_arb.
// Ports:   none (package).

package seg7_pkg;

   localparam logic [3:0] DIG_BLANK = 4'hE;
   localparam logic [3:0] DIG_DASH  = 4'hF;
   localparam int         DIG_W     = 4;
   localparam int         NUM_DIG   = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OWN0,
      ST_OWN1
   } arb_state_e;

endpackage

// File: rtl/seg7_lz_blank.sv
// rtl/seg7_lz_blank.sv - leading-zero blanking of a 6-digit hex word
//
// Purpose: replaces zero digits from digit 5 down to digit 1 with the blank
//          code until the first nonzero digit; digit 0 always passes.
//          Codes 4'hE/4'hF count as nonzero. en_i=0 passes the word as-is.
// Ports:   en_i   blanking enable
//          dig_i  24-bit input digits, nibble n = digit n
//          dig_o  24-bit output digits

module seg7_lz_blank
   import seg7_pkg::*;
(
   input  logic        en_i,
   input  logic [23:0] dig_i,
   output logic [23:0] dig_o
);

   logic lead;

   always_comb begin
      dig_o = dig_i;
      lead  = en_i;
      for (int n = NUM_DIG - 1; n >= 1; n--) begin
         if (lead && (dig_i[n*DIG_W +: DIG_W] == 4'h0)) begin
            dig_o[n*DIG_W +: DIG_W] = DIG_BLANK;
         end else begin
            lead = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_disp_arb.sv
// rtl/seg7_disp_arb.sv - two-requester arbiter for the 6-digit seven-segment display
//
// Purpose: grants the display to one of two level requesters with a minimum
//          hold time and round-robin handoff, and registers the digit word
//          (owner data with optional leading-zero blanking, or the idle
//          pattern) for the display decoder.
// Ports:   iCLK    system clock
//          iRST_N  asynchronous active-low reset
//          iREQ0   requester 0 request (level)
//          iDATA0  requester 0 digits, nibble n = digit n
//          iREQ1   requester 1 request (level)
//          iDATA1  requester 1 digits
//          oGNT0   requester 0 owns the display
//          oGNT1   requester 1 owns the display
//          oDIG    digit word, [31:24] always zero

module seg7_disp_arb
   import seg7_pkg::*;
#(
   parameter int          HOLD_CYCLES = 50000000,
   parameter bit          BLANK_LZ    = 1'b1,
   parameter logic [23:0] IDLE_PAT    = 24'hFFFFFF
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iREQ0,
   input  logic [23:0] iDATA0,
   input  logic        iREQ1,
   input  logic [23:0] iDATA1,
   output logic        oGNT0,
   output logic        oGNT1,
   output logic [31:0] oDIG
);

   localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      dig_q, dig_d;
   logic             hold_done;
   logic [23:0]      sel_data;
   logic [23:0]      blank_data;

   assign hold_done = (cnt_q == HOLD_MAX);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (iREQ0) begin
               state_d = ST_OWN0;
            end else if (iREQ1) begin
               state_d = ST_OWN1;
            end
         end
         ST_OWN0: begin
            // Release ignores the hold; yield only after the hold expires.
            if (!iREQ0) begin
               state_d = iREQ1 ? ST_OWN1 : ST_IDLE;
            end else if (hold_done && iREQ1) begin
               state_d = ST_OWN1;
            end
         end
         ST_OWN1: begin
            if (!iREQ1) begin
               state_d = iREQ0 ? ST_OWN0 : ST_IDLE;
            end else if (hold_done && iREQ0) begin
               state_d = ST_OWN0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if ((state_q != ST_IDLE) && !hold_done) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Data is selected from the next state so grant and digits move together.
   always_comb begin
      sel_data = iDATA0;
      if (state_d == ST_OWN1) begin
         sel_data = iDATA1;
      end
   end

   seg7_lz_blank u_lz_blank (
      .en_i  (BLANK_LZ),
      .dig_i (sel_data),
      .dig_o (blank_data)
   );

   always_comb begin
      dig_d = {8'h00, blank_data};
      if (state_d == ST_IDLE) begin
         dig_d = {8'h00, IDLE_PAT};
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dig_q   <= {8'h00, IDLE_PAT};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
      end
   end

   assign oGNT0 = (state_q == ST_OWN0);
   assign oGNT1 = (state_q == ST_OWN1);
   assign oDIG  = dig_q;

endmodule

// File: tb/tb_seg7_disp_arb.sv
// tb/tb_seg7_disp_arb.sv - self-checking bench for seg7_disp_arb

module tb_seg7_disp_arb;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [23:0] d0, d1;
   logic        g0_a, g1_a, g0_b, g1_b;
   logic [31:0] dig_a, dig_b;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seg7_disp_arb #(.HOLD_CYCLES(HOLD), .BLANK_LZ(1'b1)) dut_a (
      .iCLK(clk), .iRST_N(rst_n),
      .iREQ0(req0), .iDATA0(d0), .iREQ1(req1), .iDATA1(d1),
      .oGNT0(g0_a), .oGNT1(g1_a), .oDIG(dig_a)
   );

   seg7_disp_arb #(.HOLD_CYCLES(HOLD), .BLANK_LZ(1'b0)) dut_b (
      .iCLK(clk), .iRST_N(rst_n),
      .iREQ0(req0), .iDATA0(d0), .iREQ1(req1), .iDATA1(d1),
      .oGNT0(g0_b), .oGNT1(g1_b), .oDIG(dig_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Blanking rule: find the most significant nonzero digit among 5..1,
   // and every digit above it is blanked.
   function automatic logic [23:0] lzb(input logic [23:0] d);
      logic [23:0] r;
      int msd;
      r = d;
      msd = 0;
      for (int i = 5; i >= 1; i--) begin
         if (msd == 0 && d[i*4 +: 4] != 4'h0) msd = i;
      end
      for (int i = 1; i < 6; i++) begin
         if (i > msd) r[i*4 +: 4] = 4'hE;
      end
      return r;
   endfunction

   // Model: owner (-1 none) and number of cycles the owner has held the grant.
   int          m_owner = -1;
   int          m_held  = 0;
   logic [31:0] m_dig_a = 32'h00FFFFFF;
   logic [31:0] m_dig_b = 32'h00FFFFFF;

   always @(posedge clk or negedge rst_n) begin
      int nxt;
      logic mine, other;
      logic [23:0] sel;
      if (!rst_n) begin
         m_owner = -1;
         m_held  = 0;
         m_dig_a = 32'h00FFFFFF;
         m_dig_b = 32'h00FFFFFF;
      end else begin
         if (m_owner == -1) begin
            nxt = req0 ? 0 : (req1 ? 1 : -1);
         end else begin
            mine  = (m_owner == 0) ? req0 : req1;
            other = (m_owner == 0) ? req1 : req0;
            if (!mine)                        nxt = other ? 1 - m_owner : -1;
            else if (other && m_held >= HOLD) nxt = 1 - m_owner;
            else                              nxt = m_owner;
         end
         if (nxt != m_owner) m_held = (nxt == -1) ? 0 : 1;
         else if (nxt != -1) m_held = m_held + 1;
         m_owner = nxt;
         sel = (nxt == 1) ? d1 : d0;
         if (nxt == -1) begin
            m_dig_a = 32'h00FFFFFF;
            m_dig_b = 32'h00FFFFFF;
         end else begin
            m_dig_a = {8'h00, lzb(sel)};
            m_dig_b = {8'h00, sel};
         end
      end
   end

   always @(negedge clk) begin
      chk("gnt0_a", {31'd0, g0_a}, {31'd0, m_owner == 0});
      chk("gnt1_a", {31'd0, g1_a}, {31'd0, m_owner == 1});
      chk("dig_a", dig_a, m_dig_a);
      chk("gnt0_b", {31'd0, g0_b}, {31'd0, m_owner == 0});
      chk("gnt1_b", {31'd0, g1_b}, {31'd0, m_owner == 1});
      chk("dig_b", dig_b, m_dig_b);
      chk("overlap", {31'd0, g0_a & g1_a}, 32'd0);
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   initial begin
      rst_n = 1'b0;
      req0  = 1'b1;
      req1  = 1'b0;
      d0    = 24'h000123;
      d1    = 24'h654321;

      // Reset with a pending request.
      tick();
      tick();
      chk("rst_gnt0", {31'd0, g0_a}, 32'd0);
      chk("rst_gnt1", {31'd0, g1_a}, 32'd0);
      chk("rst_dig", dig_a, 32'h00FFFFFF);
      rst_n = 1'b1;
      tick();
      chk("first_gnt0", {31'd0, g0_a}, 32'd1);
      chk("blank_123", dig_a, 32'h00EEE123);
      chk("noblank_123", dig_b, 32'h00000123);

      // Blanking patterns, live-tracked while owned.
      d0 = 24'h000000;
      tick();
      chk("blank_zero", dig_a, 32'h00EEEEE0);
      chk("noblank_zero", dig_b, 32'h00000000);
      d0 = 24'h0A0000;
      tick();
      chk("blank_A", dig_a, 32'h00EA0000);
      d0 = 24'h00E00F;
      tick();
      chk("blank_E", dig_a, 32'h00EEE00F);
      d0 = 24'h000005;
      tick();
      chk("blank_5", dig_a, 32'h00EEEEE5);

      // Release at count 1 with no waiter.
      req0 = 1'b0;
      tick();
      tick();
      req0 = 1'b1;
      d0 = 24'h000123;
      tick();
      tick();
      req0 = 1'b0;
      tick();
      chk("rel_gnt0", {31'd0, g0_a}, 32'd0);
      chk("rel_dig", dig_a, 32'h00FFFFFF);

      // Tie from idle, then hold/yield sequence; drop req0 at count 1 of
      // its second ownership with req1 waiting.
      req0 = 1'b1;
      req1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hy_gnt0", {31'd0, g0_a}, {31'd0, (i < 4) || (i >= 8)});
         chk("hy_gnt1", {31'd0, g1_a}, {31'd0, (i >= 4) && (i < 8)});
         chk("hy_dig", dig_a, ((i >= 4) && (i < 8)) ? 32'h00654321 : 32'h00EEE123);
      end
      req0 = 1'b0;
      tick();
      chk("handoff_gnt0", {31'd0, g0_a}, 32'd0);
      chk("handoff_gnt1", {31'd0, g1_a}, 32'd1);
      chk("handoff_dig", dig_a, 32'h00654321);

      // Async reset while requester 1 owns.
      rst_n = 1'b0;
      #1;
      chk("arst_gnt1", {31'd0, g1_a}, 32'd0);
      chk("arst_dig", dig_a, 32'h00FFFFFF);
      #2;
      rst_n = 1'b1;

      // Counter restarts: requester 1 keeps the grant a full HOLD cycles.
      tick();
      req0 = 1'b1;
      chk("regrant_gnt1", {31'd0, g1_a}, 32'd1);
      for (int i = 1; i < 6; i++) begin
         tick();
         chk("restart_gnt1", {31'd0, g1_a}, {31'd0, i < 4});
         chk("restart_gnt0", {31'd0, g0_a}, {31'd0, i >= 4});
      end

      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      tick();
      chk("final_idle", dig_a, 32'h00FFFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
